// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS-lite memory responder: FSM states, the captured
// request record and big-endian word assembly.
package mips_mem_pkg;

  localparam int MEM_BYTES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // b0 sits at the lowest byte address and lands in the most significant byte.
  function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Byte-addressed, big-endian data memory: 32-bit read and write ports over a
// byte array that starts out all-zero and is never touched by reset.
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};
  logic [7:0] rd_byte [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    assign rd_byte[gi] = mem[rd_addr + AW'(gi)];
  end

  assign rd_data = be_word(rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        mem[wr_addr + AW'(i)] <= wr_data[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Fixed-latency valid/ready memory responder for fetch, LOAD and STORE.
// Define MIPS_MEM_STATS_EN to add saturating read/write/fault response counters.
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
`ifdef MIPS_MEM_STATS_EN
  output logic [31:0] stat_rd_cnt,
  output logic [31:0] stat_wr_cnt,
  output logic [31:0] stat_err_cnt,
`endif
  output logic        rsp_err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t      state_reg;
  logic [CW-1:0] cnt_reg;
  mem_req_t    req_reg;
  logic        req_ready_reg;
  logic        rsp_valid_reg;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  mem_req_t    req_in;
  mem_req_t    access_req;
  logic        fault;
  logic        access_fire;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] rdata_next;

  // With LATENCY==1 the access happens on the accepting edge, straight from the inputs.
  assign req_in      = {req_we, req_addr, req_wdata};
  assign access_req  = (state_reg == IDLE) ? req_in : req_reg;
  assign fault       = (access_req.addr[1:0] != 2'b00) || (access_req.addr > 32'(MEM_BYTES - 4));
  assign access_fire = ((state_reg == IDLE) && req_valid && (LATENCY == 1)) ||
                       ((state_reg == WAIT) && (cnt_reg == CW'(1)));
  assign mem_we      = access_fire && access_req.we && !fault;
  assign mem_addr    = fault ? '0 : access_req.addr[AW-1:0];
  assign rdata_next  = (fault || access_req.we) ? 32'h0 : mem_rdata;

  mips_mem_array #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_array (
    .clk    (clk),
    .wr_en  (mem_we),
    .wr_addr(mem_addr),
    .wr_data(access_req.wdata),
    .rd_addr(mem_addr),
    .rd_data(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_reg       <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_reg       <= req_in;
            req_ready_reg <= 1'b0;
            if (access_fire) begin
              state_reg     <= RESP;
              cnt_reg       <= '0;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= fault;
              rsp_rdata_reg <= rdata_next;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (access_fire) begin
            state_reg     <= RESP;
            cnt_reg       <= '0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= fault;
            rsp_rdata_reg <= rdata_next;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

`ifdef MIPS_MEM_STATS_EN
  logic [31:0] stat_rd_reg;
  logic [31:0] stat_wr_reg;
  logic [31:0] stat_err_reg;
  logic        rsp_fire;

  assign rsp_fire = rsp_valid_reg && rsp_ready;

  // Faults are tallied only as faults, regardless of direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_reg  <= 32'h0;
      stat_wr_reg  <= 32'h0;
      stat_err_reg <= 32'h0;
    end else if (rsp_fire) begin
      if (rsp_err_reg) begin
        if (stat_err_reg != 32'hFFFF_FFFF) stat_err_reg <= stat_err_reg + 32'd1;
      end else if (req_reg.we) begin
        if (stat_wr_reg != 32'hFFFF_FFFF) stat_wr_reg <= stat_wr_reg + 32'd1;
      end else begin
        if (stat_rd_reg != 32'hFFFF_FFFF) stat_rd_reg <= stat_rd_reg + 32'd1;
      end
    end
  end

  assign stat_rd_cnt  = stat_rd_reg;
  assign stat_wr_cnt  = stat_wr_reg;
  assign stat_err_cnt = stat_err_reg;
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: one LATENCY=2 and one LATENCY=1 instance.
// Define MIPS_MEM_STATS_EN to also check the response counters.
`timescale 1ns/1ps
module tb_mips_mem_responder;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req_valid_a = 1'b0, req_we_a = 1'b0, rsp_ready_a = 1'b1;
  logic [31:0] req_addr_a = '0, req_wdata_a = '0;
  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_rdata_a;

  logic        req_valid_b = 1'b0, req_we_b = 1'b0, rsp_ready_b = 1'b1;
  logic [31:0] req_addr_b = '0, req_wdata_b = '0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

`ifdef MIPS_MEM_STATS_EN
  logic [31:0] stat_rd_a, stat_wr_a, stat_err_a;
  logic [31:0] stat_rd_b, stat_wr_b, stat_err_b;
`endif

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t mon_a;
  exp_t mon_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_mem_responder #(.MEM_BYTES(4096), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a),
`ifdef MIPS_MEM_STATS_EN
    .stat_rd_cnt(stat_rd_a), .stat_wr_cnt(stat_wr_a), .stat_err_cnt(stat_err_a),
`endif
    .rsp_err(rsp_err_a)
  );

  mips_mem_responder #(.MEM_BYTES(4096), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
`ifdef MIPS_MEM_STATS_EN
    .stat_rd_cnt(stat_rd_b), .stat_wr_cnt(stat_wr_b), .stat_err_cnt(stat_err_b),
`endif
    .rsp_err(rsp_err_b)
  );

  // Monitors: pop the scoreboard whenever a response handshakes.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_a && rsp_ready_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL rsp_a_unexpected: got err=%0b rdata=%h, no response expected", rsp_err_a, rsp_rdata_a);
      end else begin
        mon_a = q_a.pop_front();
        if (rsp_err_a !== mon_a.err || rsp_rdata_a !== mon_a.rdata) begin
          errors++;
          $display("FAIL %s: got err=%0b rdata=%h expected err=%0b rdata=%h",
                   mon_a.name, rsp_err_a, rsp_rdata_a, mon_a.err, mon_a.rdata);
        end else begin
          $display("rsp_a %s: err=%0b rdata=%h", mon_a.name, rsp_err_a, rsp_rdata_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid_b && rsp_ready_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL rsp_b_unexpected: got err=%0b rdata=%h, no response expected", rsp_err_b, rsp_rdata_b);
      end else begin
        mon_b = q_b.pop_front();
        if (rsp_err_b !== mon_b.err || rsp_rdata_b !== mon_b.rdata) begin
          errors++;
          $display("FAIL %s: got err=%0b rdata=%h expected err=%0b rdata=%h",
                   mon_b.name, rsp_err_b, rsp_rdata_b, mon_b.err, mon_b.rdata);
        end else begin
          $display("rsp_b %s: err=%0b rdata=%h", mon_b.name, rsp_err_b, rsp_rdata_b);
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request, checks its latency and returns after the response handshake.
  task automatic issue(input bit b, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit exp_err, input logic [31:0] exp_rd, input string name);
    exp_t e;
    int n;
    e.err = exp_err; e.rdata = exp_rd; e.name = name;
    n = 0;
    while (!(b ? req_ready_b : req_ready_a) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: req_ready low for %0d cycles, required 1", name, n);
    end
    if (b) begin
      req_valid_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = wdata; q_b.push_back(e);
    end else begin
      req_valid_a = 1'b1; req_we_a = we; req_addr_a = addr; req_wdata_a = wdata; q_a.push_back(e);
    end
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    n = 1;
    while (!(b ? rsp_valid_b : rsp_valid_a) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check32({name, "_latency"}, 32'(n), b ? 32'd1 : 32'd2);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int acc_cyc[2];
    int rsp_cyc[2];
    int na, nr;

    repeat (2) @(posedge clk);
    #1;
    check32("reset_req_ready", {31'd0, req_ready_a}, 32'd1);
    check32("reset_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    check32("reset_rsp_rdata", rsp_rdata_a, 32'd0);
    check32("reset_rsp_err", {31'd0, rsp_err_a}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 1, 32'd16, 32'h12345678, 0, 32'h0, "store_16");
    check32("mem16_byte", {24'd0, dut_a.u_array.mem[16]}, 32'h12);
    check32("mem19_byte", {24'd0, dut_a.u_array.mem[19]}, 32'h78);
    issue(0, 0, 32'd16, 32'h0, 0, 32'h12345678, "read_16");
    issue(0, 0, 32'd5, 32'h0, 1, 32'h0, "read_misaligned_5");
    issue(0, 0, 32'd4093, 32'h0, 1, 32'h0, "read_range_4093");
    issue(0, 1, 32'd4094, 32'hCAFEF00D, 1, 32'h0, "store_fault_4094");
    check32("mem4092_4095_untouched",
            {dut_a.u_array.mem[4092], dut_a.u_array.mem[4093], dut_a.u_array.mem[4094], dut_a.u_array.mem[4095]},
            32'h0);
    issue(0, 0, 32'd4092, 32'h0, 0, 32'h0, "read_last_word_4092");

    // Backpressure: response held for 5 cycles, a store offered meanwhile must be ignored.
    rsp_ready_a = 1'b0;
    e.err = 1'b0; e.rdata = 32'h12345678; e.name = "read_16_backpressure";
    req_valid_a = 1'b1; req_we_a = 1'b0; req_addr_a = 32'd16;
    q_a.push_back(e);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 32'd16; req_wdata_a = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("bp_rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
      check32("bp_rsp_rdata", rsp_rdata_a, 32'h12345678);
      check32("bp_req_ready", {31'd0, req_ready_a}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid_a = 1'b0; rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    check32("bp_idle_req_ready", {31'd0, req_ready_a}, 32'd1);
    check32("bp_idle_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    issue(0, 0, 32'd16, 32'h0, 0, 32'h12345678, "read_16_after_ignored_store");
    issue(0, 1, 32'd20, 32'hAABBCCDD, 0, 32'h0, "store_20");
    issue(0, 0, 32'd20, 32'h0, 0, 32'hAABBCCDD, "read_20");

`ifdef MIPS_MEM_STATS_EN
    check32("stat_rd_cnt", stat_rd_a, 32'd5);
    check32("stat_wr_cnt", stat_wr_a, 32'd2);
    check32("stat_err_cnt", stat_err_a, 32'd3);
`endif

    // Reset during WAIT of a store: outputs clear at once and the store never lands.
    req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 32'd32; req_wdata_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    check32("wait_req_ready", {31'd0, req_ready_a}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check32("async_rst_req_ready", {31'd0, req_ready_a}, 32'd1);
    check32("async_rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    check32("async_rst_rsp_rdata", rsp_rdata_a, 32'd0);
    check32("async_rst_rsp_err", {31'd0, rsp_err_a}, 32'd0);
`ifdef MIPS_MEM_STATS_EN
    check32("async_rst_stat_rd", stat_rd_a, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 0, 32'd32, 32'h0, 0, 32'h0, "read_32_after_reset");

    // LATENCY=1 instance: preload, then back-to-back reads with req_valid held high.
    issue(1, 1, 32'd0, 32'h11223344, 0, 32'h0, "b_store_0");
    issue(1, 1, 32'd4, 32'h55667788, 0, 32'h0, "b_store_4");
    e.err = 1'b0; e.rdata = 32'h11223344; e.name = "b_read_0"; q_b.push_back(e);
    e.err = 1'b0; e.rdata = 32'h55667788; e.name = "b_read_4"; q_b.push_back(e);
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 32'd0;
    na = 0; nr = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; rsp_cyc[0] = 0; rsp_cyc[1] = 0;
    for (int i = 0; i < 12 && nr < 2; i++) begin
      @(negedge clk);
      if (req_valid_b && req_ready_b && na < 2) begin acc_cyc[na] = cyc; na++; end
      if (rsp_valid_b && nr < 2) begin rsp_cyc[nr] = cyc; nr++; end
      @(posedge clk); #1;
      if (na == 1) req_addr_b = 32'd4;
      if (na == 2) req_valid_b = 1'b0;
    end
    req_valid_b = 1'b0;
    check32("b2b_accept_count", 32'(na), 32'd2);
    check32("b2b_rsp_count", 32'(nr), 32'd2);
    check32("b2b_accept_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
    check32("b2b_rsp0_latency", 32'(rsp_cyc[0] - acc_cyc[0]), 32'd1);
    check32("b2b_rsp1_latency", 32'(rsp_cyc[1] - acc_cyc[1]), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check32("scoreboard_a_drained", 32'(q_a.size()), 32'd0);
    check32("scoreboard_b_drained", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
